// File: rtl/pmos_bank_seq.sv
// Staggered enable sequencer for a bank of parallel PMOS legs: one leg change per STEP_CYC cycles.
// Optional sticky ramp-abort flag `err` is built when PMOS_BANK_SEQ_ERR_EN is defined.
module pmos_bank_seq #(
   parameter int unsigned NUM_LEG  = 3,
   parameter int unsigned STEP_CYC = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_on,
   input  logic               req_off,
   output logic [NUM_LEG-1:0] leg_en,
   output logic               busy,
   output logic               on_done,
   output logic               off_done
`ifdef PMOS_BANK_SEQ_ERR_EN
   ,
   output logic               err
`endif
);

   localparam int unsigned        TW     = $clog2(STEP_CYC) + 1;
   localparam logic [TW-1:0]      Reload = TW'(STEP_CYC - 1);
   localparam logic [NUM_LEG-1:0] LegOne = NUM_LEG'(1);

   typedef enum logic [1:0] {StOff, StRampUp, StOn, StRampDown} state_e;

   state_e             state_q, state_d;
   logic [NUM_LEG-1:0] leg_q, leg_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [NUM_LEG-1:0] leg_up, leg_dn;

   // Thermometer grow/shrink by one leg from bit 0.
   assign leg_up = (leg_q << 1) | LegOne;
   assign leg_dn = leg_q >> 1;

   always_comb begin
      state_d = state_q;
      leg_d   = leg_q;
      timer_d = timer_q;
      unique case (state_q)
         StOff: begin
            if (req_on && !req_off) begin
               state_d = StRampUp;
               leg_d   = leg_up;
               timer_d = Reload;
            end
         end
         StRampUp: begin
            if (req_off) begin
               state_d = StRampDown;
               leg_d   = leg_dn;
               timer_d = Reload;
            end else if (timer_q == '0) begin
               timer_d = Reload;
               if (&leg_q) begin
                  state_d = StOn;
               end else begin
                  leg_d = leg_up;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         StOn: begin
            if (req_off) begin
               state_d = StRampDown;
               leg_d   = leg_dn;
               timer_d = Reload;
            end
         end
         StRampDown: begin
            if (req_on && !req_off) begin
               state_d = StRampUp;
               leg_d   = leg_up;
               timer_d = Reload;
            end else if (timer_q == '0) begin
               timer_d = Reload;
               if (leg_q == '0) begin
                  state_d = StOff;
               end else begin
                  leg_d = leg_dn;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d = StOff;
            leg_d   = '0;
            timer_d = Reload;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StOff;
         leg_q   <= '0;
         timer_q <= Reload;
      end else begin
         state_q <= state_d;
         leg_q   <= leg_d;
         timer_q <= timer_d;
      end
   end

   assign leg_en   = leg_q;
   assign busy     = (state_q == StRampUp) || (state_q == StRampDown);
   assign on_done  = (state_q == StOn);
   assign off_done = (state_q == StOff);

`ifdef PMOS_BANK_SEQ_ERR_EN
   logic err_q;

   // Set on any ramp reversal; cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (((state_q == StRampUp) && req_off) ||
                   ((state_q == StRampDown) && req_on && !req_off)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_pmos_bank_seq.sv
// Table-driven bench for pmos_bank_seq (NUM_LEG=3, STEP_CYC=4) with a scoreboard queue.
// Define PMOS_BANK_SEQ_ERR_EN to also check the err flag.
module tb_pmos_bank_seq;

   logic       clk;
   logic       rst;
   logic       req_on;
   logic       req_off;
   logic [2:0] leg_en;
   logic       busy;
   logic       on_done;
   logic       off_done;
`ifdef PMOS_BANK_SEQ_ERR_EN
   logic       err;
`endif

   pmos_bank_seq #(
      .NUM_LEG (3),
      .STEP_CYC(4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_on  (req_on),
      .req_off (req_off),
      .leg_en  (leg_en),
      .busy    (busy),
      .on_done (on_done),
      .off_done(off_done)
`ifdef PMOS_BANK_SEQ_ERR_EN
      ,
      .err     (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] leg;
      bit         busy;
      bit         ond;
      bit         offd;
      bit         err;
   } exp_t;

   typedef struct {
      bit   on;
      bit   off;
      int   reps;
      exp_t e;
   } vec_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_outputs(input exp_t e, input string tag);
      chk({tag, " leg_en"}, int'(leg_en), int'(e.leg));
      chk({tag, " busy"}, int'(busy), int'(e.busy));
      chk({tag, " on_done"}, int'(on_done), int'(e.ond));
      chk({tag, " off_done"}, int'(off_done), int'(e.offd));
`ifdef PMOS_BANK_SEQ_ERR_EN
      chk({tag, " err"}, int'(err), int'(e.err));
`endif
      // Thermometer form: x & (x+1) == 0
      chk({tag, " thermometer"}, int'((leg_en & (leg_en + 3'd1)) == 3'd0), 1);
   endtask

   task automatic drive_check(input bit on, input bit off, input exp_t e, input string tag);
      @(negedge clk);
      req_on  = on;
      req_off = off;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, " scoreboard empty"}, 0, 1);
      end else begin
         check_outputs(exp_q.pop_front(), tag);
      end
   endtask

   function automatic void add(bit on, bit off, int reps, logic [2:0] leg,
                               bit b, bit o, bit f, bit e);
      vec_t v;
      v.on     = on;
      v.off    = off;
      v.reps   = reps;
      v.e.leg  = leg;
      v.e.busy = b;
      v.e.ond  = o;
      v.e.offd = f;
      v.e.err  = e;
      vecs.push_back(v);
   endfunction

   initial begin
      exp_t e;

      // Full ramp up from a 1-cycle req_on pulse
      add(1, 0, 1, 3'b001, 1, 0, 0, 0);
      add(0, 0, 3, 3'b001, 1, 0, 0, 0);
      add(0, 0, 4, 3'b011, 1, 0, 0, 0);
      add(0, 0, 4, 3'b111, 1, 0, 0, 0);
      add(0, 0, 1, 3'b111, 0, 1, 0, 0);
      // Held req_on in ON is ignored
      add(1, 0, 20, 3'b111, 0, 1, 0, 0);
      // Both requests in ON: req_off wins, ramp down
      add(1, 1, 1, 3'b011, 1, 0, 0, 0);
      add(0, 0, 3, 3'b011, 1, 0, 0, 0);
      add(0, 0, 4, 3'b001, 1, 0, 0, 0);
      add(0, 0, 4, 3'b000, 1, 0, 0, 0);
      add(0, 0, 1, 3'b000, 0, 0, 1, 0);
      // Both requests in OFF, then held req_off in OFF
      add(1, 1, 5, 3'b000, 0, 0, 1, 0);
      add(0, 1, 20, 3'b000, 0, 0, 1, 0);
      // Reversal up->down at leg_en=011
      add(1, 0, 1, 3'b001, 1, 0, 0, 0);
      add(0, 0, 3, 3'b001, 1, 0, 0, 0);
      add(0, 0, 2, 3'b011, 1, 0, 0, 0);
      add(0, 1, 1, 3'b001, 1, 0, 0, 1);
      add(0, 0, 3, 3'b001, 1, 0, 0, 1);
      add(0, 0, 4, 3'b000, 1, 0, 0, 1);
      add(0, 0, 1, 3'b000, 0, 0, 1, 1);
      // Ramp up with req_on held through RAMP_UP
      add(1, 0, 1, 3'b001, 1, 0, 0, 1);
      add(1, 0, 3, 3'b001, 1, 0, 0, 1);
      add(1, 0, 4, 3'b011, 1, 0, 0, 1);
      add(1, 0, 4, 3'b111, 1, 0, 0, 1);
      add(0, 0, 1, 3'b111, 0, 1, 0, 1);
      // Reversal down->up at leg_en=011
      add(0, 1, 1, 3'b011, 1, 0, 0, 1);
      add(0, 0, 2, 3'b011, 1, 0, 0, 1);
      add(1, 0, 1, 3'b111, 1, 0, 0, 1);
      add(0, 0, 3, 3'b111, 1, 0, 0, 1);
      add(0, 0, 1, 3'b111, 0, 1, 0, 1);
      // Ramp down with req_off held through RAMP_DOWN
      add(0, 1, 1, 3'b011, 1, 0, 0, 1);
      add(0, 1, 3, 3'b011, 1, 0, 0, 1);
      add(0, 1, 4, 3'b001, 1, 0, 0, 1);
      add(0, 1, 4, 3'b000, 1, 0, 0, 1);
      add(0, 0, 1, 3'b000, 0, 0, 1, 1);

      rst     = 1'b1;
      req_on  = 1'b0;
      req_off = 1'b0;
      #12;
      e = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
      check_outputs(e, "reset");
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            drive_check(vecs[i].on, vecs[i].off, vecs[i].e, $sformatf("vec%0d.%0d", i, r));
         end
      end

      // Async reset mid-RAMP_UP at leg_en=011
      e = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b1};
      drive_check(1'b1, 1'b0, e, "rst_seq ramp");
      for (int r = 0; r < 3; r++) drive_check(1'b0, 1'b0, e, "rst_seq ramp");
      e.leg = 3'b011;
      for (int r = 0; r < 2; r++) drive_check(1'b0, 1'b0, e, "rst_seq ramp");
      #2;
      rst = 1'b1;
      #1;
      e = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
      check_outputs(e, "rst_async");
      repeat (2) @(posedge clk);
      #1;
      check_outputs(e, "rst_held");
      @(negedge clk);
      rst = 1'b0;
      drive_check(1'b0, 1'b0, e, "post_rst idle");
      e.leg  = 3'b001;
      e.busy = 1'b1;
      e.offd = 1'b0;
      drive_check(1'b1, 1'b0, e, "post_rst start");

      chk("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
